// File: rtl/spifs_xip_seq.sv
// -----------------------------------------------------------------------------
// spifs_xip_seq
//
// Execute-in-place read sequencer. Turns one 24-bit flash read request into a
// 64-bit SPI flash read (opcode + address, then 32 bits of data) by driving
// an APB-attached SPI controller:
//   TX_1 <- {CMD, addr}, TX_0 <- 0, CTRL <- CTRL_CFG, CTRL <- CTRL_CFG | GO,
//   wait for completion, read RX_0 and return it as the response.
//
// Build option:
//   SPIFS_XIP_IRQ_EN  defined     : completion is signalled by irq_i; the
//                                   APB bus idles while waiting.
//                     not defined : completion is found by polling CTRL
//                                   until the GO bit reads back 0; irq_i is
//                                   unused.
//
// Ports:
//   pclk_i, presetn_i          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    request handshake, req_addr_i = flash address
//   rsp_valid_o/rsp_ready_i    response handshake, rsp_data_o = read word
//   paddr_o .. penable_o       APB master request side
//   prdata_i, pready_i         APB master response side
//   irq_i                      SPI transfer-done interrupt
//   busy_o                     high whenever a sequence is in progress
// -----------------------------------------------------------------------------
module spifs_xip_seq #(
  parameter logic [4:0]  TX0_ADDR  = 5'h00,
  parameter logic [4:0]  TX1_ADDR  = 5'h04,
  parameter logic [4:0]  CTRL_ADDR = 5'h10,
  parameter logic [31:0] CTRL_CFG  = 32'h0000_2040,
  parameter int unsigned GO_BIT    = 8,
  parameter logic [7:0]  CMD       = 8'h03
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  paddr_o,
  output logic [31:0] pwdata_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        irq_i,
  output logic        busy_o
);

  localparam logic [31:0] CTRL_GO = CTRL_CFG | (32'd1 << GO_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_TX1,
    S_WR_TX0,
    S_WR_CTRL,
    S_WR_GO,
    S_WAIT_DONE,
    S_RD_RX,
    S_RSP
  } state_e;

  state_e      state_q,    state_d;
  logic        access_q,   access_d;   // 0 = SETUP phase, 1 = ACCESS phase
  logic [23:0] addr_q,     addr_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic xfer_state;  // current state owns an APB transfer
  logic xfer_done;   // that transfer completes on this edge

  // Which states drive the bus. Polling turns WAIT_DONE into a bus state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    xfer_state = 1'b0;
    case (state_q)
      S_WR_TX1, S_WR_TX0, S_WR_CTRL, S_WR_GO, S_RD_RX: xfer_state = 1'b1;
`ifdef SPIFS_XIP_IRQ_EN
      S_WAIT_DONE: xfer_state = 1'b0;
`else
      S_WAIT_DONE: xfer_state = 1'b1;
`endif
      default: xfer_state = 1'b0;
    endcase
  end

  // pready_i only counts during ACCESS of a bus-owning state.
  assign xfer_done = xfer_state & access_q & pready_i;

`ifndef SPIFS_XIP_IRQ_EN
  logic unused_irq;
  assign unused_irq = irq_i;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every register here has an async reset; reset asserted mid-transfer
  // returns to IDLE at once, which drops psel_o/penable_o without waiting for
  // a clock edge.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q    <= S_IDLE;
      access_q   <= 1'b0;
      addr_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      state_q    <= state_d;
      access_q   <= access_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    access_d   = access_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;

    // SETUP always lasts one cycle; ACCESS ends on pready_i, and the next
    // transfer (or the next poll) restarts in SETUP.
    if (xfer_state) begin
      if (!access_q)     access_d = 1'b1;
      else if (pready_i) access_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          state_d = S_WR_TX1;
        end
      end
      S_WR_TX1:  if (xfer_done) state_d = S_WR_TX0;
      S_WR_TX0:  if (xfer_done) state_d = S_WR_CTRL;
      S_WR_CTRL: if (xfer_done) state_d = S_WR_GO;
      S_WR_GO:   if (xfer_done) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
`ifdef SPIFS_XIP_IRQ_EN
        if (irq_i) state_d = S_RD_RX;
`else
        // GO still set means the SPI shift is running: poll again.
        if (xfer_done && !prdata_i[GO_BIT]) state_d = S_RD_RX;
`endif
      end
      S_RD_RX: begin
        if (xfer_done) begin
          rsp_data_d = prdata_i;
          state_d    = S_RSP;
        end
      end
      S_RSP:   if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Address/data/direction are a pure function of the state, so they
  // are stable from SETUP through the end of ACCESS.
  // ---------------------------------------------------------------------------
  always_comb begin
    paddr_o  = '0;
    pwdata_o = '0;
    pwrite_o = 1'b0;
    case (state_q)
      S_WR_TX1: begin
        paddr_o  = TX1_ADDR;
        pwdata_o = {CMD, addr_q};
        pwrite_o = 1'b1;
      end
      S_WR_TX0: begin
        paddr_o  = TX0_ADDR;
        pwdata_o = 32'h0;
        pwrite_o = 1'b1;
      end
      S_WR_CTRL: begin
        paddr_o  = CTRL_ADDR;
        pwdata_o = CTRL_CFG;
        pwrite_o = 1'b1;
      end
      S_WR_GO: begin
        paddr_o  = CTRL_ADDR;
        pwdata_o = CTRL_GO;
        pwrite_o = 1'b1;
      end
`ifndef SPIFS_XIP_IRQ_EN
      S_WAIT_DONE: paddr_o = CTRL_ADDR;
`endif
      S_RD_RX: paddr_o = TX0_ADDR;
      default: ;
    endcase

    psel_o      = xfer_state;
    penable_o   = xfer_state & access_q;
    req_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    rsp_valid_o = (state_q == S_RSP);
    rsp_data_o  = rsp_data_q;
  end

endmodule

// File: tb/tb_spifs_xip_seq.sv
// -----------------------------------------------------------------------------
// tb_spifs_xip_seq
//
// Self-checking bench for spifs_xip_seq. A behavioural APB slave model logs
// every completed transfer; each request's log is compared against the
// transfer list the read sequence must produce, and the response word against
// the RX word the slave returned. Directed vectors come from a table, then a
// mid-transfer reset sequence, then randomized requests.
// Honours SPIFS_XIP_IRQ_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_spifs_xip_seq;

  logic        pclk_i = 1'b0;
  logic        presetn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [23:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        irq_i;
  logic        busy_o;

  spifs_xip_seq dut (
    .pclk_i      (pclk_i),
    .presetn_i   (presetn_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pwrite_o    (pwrite_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .irq_i       (irq_i),
    .busy_o      (busy_o)
  );

  always #5 pclk_i = ~pclk_i;

  // One completed APB transfer; read data is not logged.
  typedef struct packed {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic [23:0] addr;
    int unsigned polls;      // CTRL reads that still show GO=1
    int unsigned wait_n;     // ACCESS wait cycles before pready
    int unsigned rsp_delay;  // cycles rsp_ready_i stays low
    int unsigned irq_d;      // cycles from GO write to irq pulse
    logic [31:0] rx;         // word the slave returns for RX_0
    logic [31:0] exp_data;   // expected rsp_data_o
  } vec_t;

  xfer_t       log_q[$];
  xfer_t       exp_q[$];
  int unsigned cur_wait   = 0;
  int unsigned polls_left = 0;
  int unsigned acc_cnt    = 0;
  int unsigned irq_delay  = 0;
  int unsigned irq_cnt    = 0;
  logic [31:0] rx_word    = '0;
  bit          stall_ctrl = 0;
  bit          irq_done   = 1;
  bit          have_su    = 0;
  logic [4:0]  su_addr;
  logic [31:0] su_wdata;
  logic        su_wr;
  int          stab_err   = 0;
  int          n_tests    = 0;
  int          n_fail     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // APB slave model, driven on the falling edge. Also checks that address,
  // data and direction hold from SETUP through ACCESS, and injects stray
  // pready outside ACCESS.
  // ---------------------------------------------------------------------------
  always @(negedge pclk_i) begin
    pready_i = 1'b0;
    prdata_i = $urandom;
    if (!presetn_i) begin
      acc_cnt = 0;
      have_su = 0;
    end else if (psel_o && !penable_o) begin
      su_addr  = paddr_o;
      su_wdata = pwdata_o;
      su_wr    = pwrite_o;
      have_su  = 1;
      acc_cnt  = 0;
      pready_i = ($urandom_range(0, 1) == 1);
    end else if (psel_o && penable_o) begin
      if (!have_su || paddr_o !== su_addr || pwdata_o !== su_wdata || pwrite_o !== su_wr)
        stab_err++;
      if (!(stall_ctrl && paddr_o == 5'h10 && pwrite_o) && acc_cnt >= cur_wait) begin
        pready_i = 1'b1;
        have_su  = 0;
        if (!pwrite_o && paddr_o == 5'h10) begin
          prdata_i = (polls_left > 0) ? 32'h0000_2140 : 32'h0000_2040;
          if (polls_left > 0) polls_left--;
        end else if (!pwrite_o && paddr_o == 5'h00) begin
          prdata_i = rx_word;
        end
        log_q.push_back({paddr_o, pwrite_o, pwrite_o ? pwdata_o : 32'h0});
      end
      acc_cnt++;
    end else begin
      if (penable_o) stab_err++;
      have_su  = 0;
      acc_cnt  = 0;
      pready_i = ($urandom_range(0, 1) == 1);
    end
  end

`ifdef SPIFS_XIP_IRQ_EN
  // One irq pulse irq_delay cycles after the GO write has been accepted.
  always @(negedge pclk_i) begin
    irq_i = 1'b0;
    if (log_q.size() >= 4 && !irq_done) begin
      if (irq_cnt >= irq_delay) begin
        irq_i    = 1'b1;
        irq_done = 1;
      end
      irq_cnt++;
    end
  end
`else
  // irq_i must have no effect when completion is polled.
  always @(negedge pclk_i) irq_i = ($urandom_range(0, 1) == 1);
`endif

  // Reference transfer list for one request.
  task automatic build_exp(input logic [23:0] addr, input int unsigned polls);
    exp_q.delete();
    exp_q.push_back({5'h04, 1'b1, 8'h03, addr});
    exp_q.push_back({5'h00, 1'b1, 32'h0});
    exp_q.push_back({5'h10, 1'b1, 32'h0000_2040});
    exp_q.push_back({5'h10, 1'b1, 32'h0000_2140});
`ifndef SPIFS_XIP_IRQ_EN
    for (int i = 0; i <= int'(polls); i++) exp_q.push_back({5'h10, 1'b0, 32'h0});
`endif
    exp_q.push_back({5'h00, 1'b0, 32'h0});
  endtask

  task automatic run_req(input string tag, input vec_t v);
    int          cyc;
    bit          hold_ok;
    logic [31:0] held;
    log_q.delete();
    polls_left = v.polls;
    cur_wait   = v.wait_n;
    rx_word    = v.rx;
    irq_delay  = v.irq_d;
    irq_cnt    = 0;
    irq_done   = 0;
    @(negedge pclk_i);
    req_addr_i  = v.addr;
    req_valid_i = 1'b1;
    @(negedge pclk_i);
    req_valid_i = 1'b0;
    req_addr_i  = 24'($urandom);
    check({tag, ":accept"}, {62'd0, req_ready_o, busy_o}, 64'd1);
    cyc = 0;
    while (!rsp_valid_o && cyc < 3000) begin
      @(negedge pclk_i);
      cyc++;
    end
    check({tag, ":rsp_seen"}, {63'd0, rsp_valid_o}, 64'd1);
    if (rsp_valid_o) begin
      held    = rsp_data_o;
      hold_ok = 1;
      repeat (v.rsp_delay) begin
        @(negedge pclk_i);
        if (!rsp_valid_o || rsp_data_o !== held || req_ready_o) hold_ok = 0;
      end
      check({tag, ":rsp_hold"}, {63'd0, hold_ok}, 64'd1);
      check({tag, ":rsp_data"}, {32'd0, rsp_data_o}, {32'd0, v.exp_data});
      // Offer a new request in the handshake cycle: it must not be taken.
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b1;
      req_addr_i  = 24'($urandom);
      @(negedge pclk_i);
      rsp_ready_i = 1'b0;
      check({tag, ":idle_after"}, {61'd0, req_ready_o, busy_o, rsp_valid_o}, 64'd4);
      req_valid_i = 1'b0;
    end
    build_exp(v.addr, v.polls);
    check({tag, ":xfer_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s:xfer%0d", tag, i), {26'd0, log_q[i]}, {26'd0, exp_q[i]});
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   cyc;
    bit   found;

    vecs[0] = '{24'h12_3456, 3, 1, 5, 20, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{24'h00_0000, 0, 0, 0,  2, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{24'hFF_FFFF, 1, 3, 1,  7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{24'hA5_5A0F, 5, 0, 2,  1, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{24'h80_0001, 0, 2, 0, 30, 32'h8000_0001, 32'h8000_0001};
    vecs[5] = '{24'h00_0100, 2, 1, 3,  4, 32'h0F0F_F0F0, 32'h0F0F_F0F0};

    presetn_i   = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge pclk_i);
    check("reset:bus_idle", {62'd0, psel_o, penable_o}, 64'd0);
    presetn_i = 1'b1;
    @(negedge pclk_i);
    check("reset:handshake", {61'd0, req_ready_o, busy_o, rsp_valid_o}, 64'd4);
    check("reset:apb", {26'd0, paddr_o, pwrite_o, pwdata_o}, 64'd0);
    check("reset:rsp_data", {32'd0, rsp_data_o}, 64'd0);

    for (int i = 0; i < 6; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Reset during WR_CTRL ACCESS: the transfer must be abandoned.
    log_q.delete();
    cur_wait   = 0;
    polls_left = 0;
    irq_done   = 1;
    stall_ctrl = 1;
    @(negedge pclk_i);
    req_addr_i  = 24'h55_AA55;
    req_valid_i = 1'b1;
    @(negedge pclk_i);
    req_valid_i = 1'b0;
    found = 0;
    cyc   = 0;
    while (!found && cyc < 200) begin
      if (psel_o && penable_o && paddr_o == 5'h10 && pwrite_o) found = 1;
      else begin
        @(negedge pclk_i);
        cyc++;
      end
    end
    check("rst_mid:reached_ctrl", {63'd0, found}, 64'd1);
    #2 presetn_i = 1'b0;
    #1 check("rst_mid:bus_drop", {61'd0, psel_o, penable_o, busy_o}, 64'd0);
    @(negedge pclk_i);
    presetn_i  = 1'b1;
    stall_ctrl = 0;
    check("rst_mid:no_ctrl_done", 64'(log_q.size()), 64'd2);
    check("rst_mid:idle", {62'd0, req_ready_o, busy_o}, 64'd2);
    rv = '{24'h55_AA55, 1, 1, 1, 5, 32'hCAFE_F00D, 32'hCAFE_F00D};
    run_req("rst_mid:restart", rv);

    for (int i = 0; i < 20; i++) begin
      rv.addr      = 24'($urandom);
      rv.polls     = $urandom_range(0, 4);
      rv.wait_n    = $urandom_range(0, 3);
      rv.rsp_delay = $urandom_range(0, 3);
      rv.irq_d     = $urandom_range(1, 25);
      rv.rx        = $urandom;
      rv.exp_data  = rv.rx;
      run_req($sformatf("rand%0d", i), rv);
    end

    check("apb_stability", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spifs_xip_seq.md
SPIFS_XIP_SEQ -- requirements
Module: spifs_xip_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TX0_ADDR, 5'h00, TX_0/RX_0 register offset
- TX1_ADDR, 5'h04, TX_1 register offset
- CTRL_ADDR, 5'h10, CTRL register offset
- CTRL_CFG, 32'h0000_2040, CTRL value written at start (char_len 64, ASS set, GO clear)
- GO_BIT, 8, CTRL GO bit index
- CMD, 8'h03, flash read opcode
REQ-002 Ports (name, direction, width, meaning):
- pclk_i, in, 1, sole clock
- presetn_i, in, 1, asynchronous active-low reset
- req_valid_i, in, 1, read request valid
- req_ready_o, out, 1, request accepted
- req_addr_i, in, 24, flash byte address
- rsp_valid_o, out, 1, read data valid
- rsp_ready_i, in, 1, read data consumed
- rsp_data_o, out, 32, read data
- paddr_o, out, 5, APB address to SPI controller
- pwdata_o, out, 32, APB write data
- pwrite_o, out, 1, APB write
- psel_o, out, 1, APB select
- penable_o, out, 1, APB enable
- prdata_i, in, 32, APB read data
- pready_i, in, 1, APB ready
- irq_i, in, 1, SPI transfer-done interrupt
- busy_o, out, 1, sequence in progress

Function
REQ-003 The block SHALL be an APB master that converts one request into a 64-bit SPI flash read on the downstream SPI controller.
REQ-004 FSM states SHALL be IDLE, WR_TX1, WR_TX0, WR_CTRL, WR_GO, WAIT_DONE, RD_RX, RSP.
REQ-005 req_ready_o SHALL be 1 only in IDLE. A handshake SHALL latch req_addr_i and move to WR_TX1 on the next edge.
REQ-006 Each APB transfer SHALL be one SETUP cycle (psel_o=1, penable_o=0), then ACCESS (psel_o=1, penable_o=1) held until pready_i=1. The state advances on that edge and the next transfer's SETUP starts on the following cycle.
REQ-007 paddr_o, pwdata_o and pwrite_o SHALL stay stable from SETUP through the end of ACCESS.
REQ-008 The write sequence SHALL be:
- WR_TX1: TX1_ADDR <- {CMD, addr}
- WR_TX0: TX0_ADDR <- 32'h0
- WR_CTRL: CTRL_ADDR <- CTRL_CFG
- WR_GO: CTRL_ADDR <- CTRL_CFG | (1<<GO_BIT)
REQ-009 WAIT_DONE behaviour depends on configuration (REQ-016/017).
REQ-010 RD_RX SHALL perform an APB read of TX0_ADDR and capture prdata_i into rsp_data_o on the pready_i edge.
REQ-011 RSP SHALL hold rsp_valid_o=1 and rsp_data_o stable until rsp_ready_i=1, then return to IDLE. A new request SHALL NOT be accepted in that same cycle.
REQ-012 busy_o SHALL be 1 in every state except IDLE.
REQ-013 pready_i outside ACCESS and irq_i outside WAIT_DONE SHALL be ignored.
REQ-014 No timeout: a stalled pready_i or missing completion holds the FSM in its current state indefinitely.

Reset
REQ-015 presetn_i low SHALL asynchronously force:
- state IDLE
- psel_o, penable_o, pwrite_o, rsp_valid_o, busy_o = 0
- paddr_o, pwdata_o, rsp_data_o, latched address = 0
- req_ready_o = 1 after release
Assertion mid-transfer SHALL abort the transfer immediately; no APB cycle completes.

Configuration
REQ-016 With SPIFS_XIP_IRQ_EN defined, WAIT_DONE SHALL idle the bus (psel_o=0) until irq_i=1, then go to RD_RX.
REQ-017 Without SPIFS_XIP_IRQ_EN, WAIT_DONE SHALL repeatedly APB-read CTRL_ADDR and go to RD_RX on the first read where prdata_i[GO_BIT]=0. irq_i SHALL be unused.

Verification
REQ-018 IRQ_EN; slave with pready_i one cycle after penable_o; request addr 24'h12_3456 -> four writes in order:
- 5'h04 <- 32'h0312_3456
- 5'h00 <- 0
- 5'h10 <- 32'h2040
- 5'h10 <- 32'h2140
REQ-019 IRQ_EN; irq_i pulsed 20 cycles after WR_GO; RX read returns 32'hDEAD_BEEF -> rsp_valid_o=1 with rsp_data_o=32'hDEAD_BEEF.
REQ-020 No IRQ_EN; CTRL reads return GO=1 three times, then 0 -> exactly four CTRL reads, then one RX read.
REQ-021 rsp_ready_i low for 5 cycles -> rsp_valid_o and data held, req_ready_o=0, then IDLE one cycle after the handshake.
REQ-022 presetn_i asserted during WR_CTRL ACCESS -> psel_o/penable_o drop the same cycle; after release the next request restarts at WR_TX1.
